inst_pipe_tracker: RTL and testbench

//  Carries the instruction word of each in-flight instruction through the ID, EX and MEM stages.
//  Its registered inst_id, inst_ex and inst_mem are the instruction views read by the ID/EX forwarding-select logic.

---
 rtl/inst_pipe_tracker.sv | 149 ++++++++++++++
 tb/tb_inst_pipe_tracker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_pipe_tracker.sv
// inst_pipe_tracker: carries the instruction word of each in-flight
// instruction through ID, EX and MEM/WB. It also owns the load-use bubble,
// the redirect flush and the external hold.
// Optional feature macro: INST_PIPE_PERF_EN enables the perf_stall_cnt and
// perf_flush_cnt counters. When the macro is undefined, both ports read 0.
module inst_pipe_tracker #(
    parameter logic [31:0] NOP_INST          = 32'h0000_0013,
    parameter int unsigned LOAD_STALL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_fetch,
    input  logic        fetch_valid,
    input  logic        ext_stall,
    input  logic        redirect,
    output logic [31:0] inst_id,
    output logic [31:0] inst_ex,
    output logic [31:0] inst_mem,
    output logic        valid_id,
    output logic        valid_ex,
    output logic        valid_mem,
    output logic        pc_stall,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    localparam int unsigned CW = $clog2(LOAD_STALL_CYCLES + 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {RUN, STALL} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           hazard;
    logic           stall_active;
    logic           bubble;

    logic [6:0] opcode_ex, opcode_id;
    logic [4:0] rd_ex, rs1_id, rs2_id;
    logic       uses_rs1, uses_rs2;

    assign opcode_ex = inst_ex[6:0];
    assign rd_ex     = inst_ex[11:7];
    assign opcode_id = inst_id[6:0];
    assign rs1_id    = inst_id[19:15];
    assign rs2_id    = inst_id[24:20];

    // Load-use detect between the valid load in EX and the source operands read in ID
    always_comb begin
        uses_rs1 = !(opcode_id == OP_LUI || opcode_id == OP_AUIPC || opcode_id == OP_JAL);
        uses_rs2 = (opcode_id == OP_RTYPE) || (opcode_id == OP_STORE) || (opcode_id == OP_BRANCH);
        hazard   = valid_ex && (opcode_ex == OP_LOAD) && (rd_ex != 5'd0) &&
                   ((uses_rs1 && (rd_ex == rs1_id)) || (uses_rs2 && (rd_ex == rs2_id)));
    end

    // Stall FSM next state; a redirect aborts any bubble sequence in progress
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        stall_active = (state == STALL) || hazard;
        if (redirect) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
        end else if (state == RUN) begin
            if (hazard && (LOAD_STALL_CYCLES > 1)) begin
                state_nxt = STALL;
                cnt_nxt   = CW'(LOAD_STALL_CYCLES - 1);
            end
        end else begin
            if (cnt <= CW'(1)) begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt - CW'(1);
            end
        end
    end

    assign pc_stall = ext_stall | (!redirect & stall_active);
    assign bubble   = !ext_stall & !redirect & stall_active;

    // FSM state and bubble counter; frozen while the memory holds the pipe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else if (!ext_stall) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Instruction/valid pipeline: flush, bubble-insert or advance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inst_id   <= NOP_INST;
            inst_ex   <= NOP_INST;
            inst_mem  <= NOP_INST;
            valid_id  <= 1'b0;
            valid_ex  <= 1'b0;
            valid_mem <= 1'b0;
        end else if (!ext_stall) begin
            inst_mem  <= inst_ex;
            valid_mem <= valid_ex;
            if (redirect) begin
                inst_ex  <= NOP_INST;
                valid_ex <= 1'b0;
                inst_id  <= NOP_INST;
                valid_id <= 1'b0;
            end else if (stall_active) begin
                inst_ex  <= NOP_INST;
                valid_ex <= 1'b0;
            end else begin
                inst_ex  <= inst_id;
                valid_ex <= valid_id;
                inst_id  <= fetch_valid ? inst_fetch : NOP_INST;
                valid_id <= fetch_valid;
            end
        end
    end

`ifdef INST_PIPE_PERF_EN
    // Bubble-cycle and redirect counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (bubble)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (!ext_stall && redirect)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`else
    logic unused_bubble;
    assign unused_bubble  = bubble;
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_pipe_tracker.sv
// Testbench for inst_pipe_tracker. Three instances with LOAD_STALL_CYCLES
// set to 1, 2 and 3 share one input stream. Each instance is compared
// every cycle against an abstract model of the pipeline: a three-slot
// array plus an "owed bubbles" count.
module tb_inst_pipe_tracker;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [6:0]  LOAD = 7'b0000011, LUI = 7'b0110111, AUIPC = 7'b0010111,
                            JAL = 7'b1101111, RTYPE = 7'b0110011, STORE = 7'b0100011,
                            BRANCH = 7'b1100011, OPIMM = 7'b0010011, JALR = 7'b1100111;

    localparam logic [31:0] LW_X5  = 32'h0000_A283; // lw   x5,0(x1)
    localparam logic [31:0] ADD_65 = 32'h0072_8333; // add  x6,x5,x7
    localparam logic [31:0] LW_X0  = 32'h0000_A003; // lw   x0,0(x1)
    localparam logic [31:0] ADD_00 = 32'h0000_0333; // add  x6,x0,x0
    localparam logic [31:0] LUI_X5 = 32'h0000_12B7; // lui  x5,0x1
    localparam logic [31:0] BEQ    = 32'h0020_8063; // beq  x1,x2,0

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst_fetch = '0;
    logic        fetch_valid = 1'b0;
    logic        ext_stall = 1'b0;
    logic        redirect = 1'b0;

    logic [31:0] o_id[3], o_ex[3], o_mem[3], o_pst[3], o_pfl[3];
    logic        o_vid[3], o_vex[3], o_vmem[3], o_pcs[3];

    always #5 clk = ~clk;

    inst_pipe_tracker #(.NOP_INST(NOP), .LOAD_STALL_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .inst_fetch(inst_fetch), .fetch_valid(fetch_valid),
        .ext_stall(ext_stall), .redirect(redirect),
        .inst_id(o_id[0]), .inst_ex(o_ex[0]), .inst_mem(o_mem[0]),
        .valid_id(o_vid[0]), .valid_ex(o_vex[0]), .valid_mem(o_vmem[0]),
        .pc_stall(o_pcs[0]), .perf_stall_cnt(o_pst[0]), .perf_flush_cnt(o_pfl[0]));

    inst_pipe_tracker #(.NOP_INST(NOP), .LOAD_STALL_CYCLES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .inst_fetch(inst_fetch), .fetch_valid(fetch_valid),
        .ext_stall(ext_stall), .redirect(redirect),
        .inst_id(o_id[1]), .inst_ex(o_ex[1]), .inst_mem(o_mem[1]),
        .valid_id(o_vid[1]), .valid_ex(o_vex[1]), .valid_mem(o_vmem[1]),
        .pc_stall(o_pcs[1]), .perf_stall_cnt(o_pst[1]), .perf_flush_cnt(o_pfl[1]));

    inst_pipe_tracker #(.NOP_INST(NOP), .LOAD_STALL_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .inst_fetch(inst_fetch), .fetch_valid(fetch_valid),
        .ext_stall(ext_stall), .redirect(redirect),
        .inst_id(o_id[2]), .inst_ex(o_ex[2]), .inst_mem(o_mem[2]),
        .valid_id(o_vid[2]), .valid_ex(o_vex[2]), .valid_mem(o_vmem[2]),
        .pc_stall(o_pcs[2]), .perf_stall_cnt(o_pst[2]), .perf_flush_cnt(o_pfl[2]));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: slot 0 = ID, 1 = EX, 2 = MEM; owed = bubbles still due
    int          m_lsc[3] = '{1, 2, 3};
    logic [31:0] m_inst[3][3];
    bit          m_val[3][3];
    int          m_owed[3];
    int unsigned m_pst[3], m_pfl[3];
    bit          m_known = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_hazard(input logic [31:0] ex, input bit vex, input logic [31:0] id);
        logic [6:0] op;
        logic [4:0] rd;
        bit r1, r2;
        op = id[6:0];
        rd = ex[11:7];
        r1 = !(op == LUI || op == AUIPC || op == JAL) && (id[19:15] == rd);
        r2 = (op == RTYPE || op == STORE || op == BRANCH) && (id[24:20] == rd);
        return vex && (ex[6:0] == LOAD) && (rd != 5'd0) && (r1 || r2);
    endfunction

    function automatic bit m_stalling(input int k);
        return (m_owed[k] > 0) || m_hazard(m_inst[k][1], m_val[k][1], m_inst[k][0]);
    endfunction

    task automatic check_all();
        logic [31:0] e_pst, e_pfl;
        for (int k = 0; k < 3; k++) begin
`ifdef INST_PIPE_PERF_EN
            e_pst = m_pst[k];
            e_pfl = m_pfl[k];
`else
            e_pst = '0;
            e_pfl = '0;
`endif
            check_eq($sformatf("L%0d inst_id", k+1),   o_id[k],   m_inst[k][0]);
            check_eq($sformatf("L%0d inst_ex", k+1),   o_ex[k],   m_inst[k][1]);
            check_eq($sformatf("L%0d inst_mem", k+1),  o_mem[k],  m_inst[k][2]);
            check_eq($sformatf("L%0d valid_id", k+1),  32'(o_vid[k]),  32'(m_val[k][0]));
            check_eq($sformatf("L%0d valid_ex", k+1),  32'(o_vex[k]),  32'(m_val[k][1]));
            check_eq($sformatf("L%0d valid_mem", k+1), 32'(o_vmem[k]), 32'(m_val[k][2]));
            check_eq($sformatf("L%0d pc_stall", k+1),  32'(o_pcs[k]),
                     32'(ext_stall || (!redirect && m_stalling(k))));
            check_eq($sformatf("L%0d perf_stall", k+1), o_pst[k], e_pst);
            check_eq($sformatf("L%0d perf_flush", k+1), o_pfl[k], e_pfl);
        end
    endtask

    task automatic model_edge();
        bit st;
        for (int k = 0; k < 3; k++) begin
            st = m_stalling(k);
            if (!rst_n) begin
                for (int s = 0; s < 3; s++) begin
                    m_inst[k][s] = NOP;
                    m_val[k][s]  = 1'b0;
                end
                m_owed[k] = 0;
                m_pst[k]  = 0;
                m_pfl[k]  = 0;
            end else if (ext_stall) begin
                // everything frozen
            end else if (redirect) begin
                m_inst[k][2] = m_inst[k][1]; m_val[k][2] = m_val[k][1];
                m_inst[k][1] = NOP;          m_val[k][1] = 1'b0;
                m_inst[k][0] = NOP;          m_val[k][0] = 1'b0;
                m_owed[k] = 0;
                m_pfl[k]++;
            end else if (st) begin
                m_inst[k][2] = m_inst[k][1]; m_val[k][2] = m_val[k][1];
                m_inst[k][1] = NOP;          m_val[k][1] = 1'b0;
                m_owed[k] = (m_owed[k] > 0) ? m_owed[k] - 1 : m_lsc[k] - 1;
                m_pst[k]++;
            end else begin
                m_inst[k][2] = m_inst[k][1]; m_val[k][2] = m_val[k][1];
                m_inst[k][1] = m_inst[k][0]; m_val[k][1] = m_val[k][0];
                m_inst[k][0] = fetch_valid ? inst_fetch : NOP;
                m_val[k][0]  = fetch_valid;
            end
        end
        if (!rst_n) m_known = 1'b1;
    endtask

    task automatic step(input bit r, input logic [31:0] f, input bit fv, input bit es, input bit rd);
        rst_n = r; inst_fetch = f; fetch_valid = fv; ext_stall = es; redirect = rd;
        @(negedge clk);
        if (m_known) check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] op;
        logic [2:0] f3;
        case ($urandom_range(0, 8))
            0, 1:    op = LOAD;
            2:       op = RTYPE;
            3:       op = STORE;
            4:       op = BRANCH;
            5:       op = LUI;
            6:       op = AUIPC;
            7:       op = JAL;
            default: op = ($urandom_range(0, 1) == 0) ? OPIMM : JALR;
        endcase
        f3 = (op == LOAD) ? 3'b010 : 3'b000;
        return {7'b0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), f3,
                5'($urandom_range(0, 3)), op};
    endfunction

    initial begin
        bit es, rd, prev_es, prev_rd, r;

        // reset held for two cycles
        step(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1; fetch_valid = 1'b0; ext_stall = 1'b0; redirect = 1'b0;
        #1;
        check_eq("reset inst_id",  o_id[2],  32'h0000_0013);
        check_eq("reset inst_ex",  o_ex[2],  32'h0000_0013);
        check_eq("reset inst_mem", o_mem[2], 32'h0000_0013);
        check_eq("reset valid_id", 32'(o_vid[0]), 32'd0);
        check_eq("reset pc_stall", 32'(o_pcs[0]), 32'd0);

        // load-use: lw x5 then add x6,x5,x7
        step(1'b1, LW_X5,  1'b1, 1'b0, 1'b0);
        step(1'b1, ADD_65, 1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b1, NOP, 1'b1, 1'b0, 1'b0);

        // no false hazard: lw x0 / add x0 and lw x5 / lui x5
        step(1'b1, LW_X0,  1'b1, 1'b0, 1'b0);
        step(1'b1, ADD_00, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, NOP, 1'b1, 1'b0, 1'b0);
        step(1'b1, LW_X5,  1'b1, 1'b0, 1'b0);
        step(1'b1, LUI_X5, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, NOP, 1'b1, 1'b0, 1'b0);

        // redirect with beq in EX
        step(1'b1, BEQ, 1'b1, 1'b0, 1'b0);
        step(1'b1, NOP, 1'b1, 1'b0, 1'b0);
        step(1'b1, NOP, 1'b1, 1'b0, 1'b1);
        repeat (2) step(1'b1, NOP, 1'b1, 1'b0, 1'b0);

        // redirect in the middle of a multi-cycle stall
        step(1'b1, LW_X5,  1'b1, 1'b0, 1'b0);
        step(1'b1, ADD_65, 1'b1, 1'b0, 1'b0);
        step(1'b1, NOP,    1'b1, 1'b0, 1'b0);
        step(1'b1, NOP,    1'b1, 1'b0, 1'b0);
        step(1'b1, NOP,    1'b1, 1'b0, 1'b1);
        repeat (4) step(1'b1, NOP, 1'b1, 1'b0, 1'b0);

        // ext_stall with redirect held, then redirect acted on as ext_stall drops
        step(1'b1, BEQ, 1'b1, 1'b0, 1'b0);
        step(1'b1, NOP, 1'b1, 1'b0, 1'b0);
        step(1'b1, NOP, 1'b1, 1'b1, 1'b1);
        step(1'b1, NOP, 1'b1, 1'b1, 1'b1);
        step(1'b1, NOP, 1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b1, NOP, 1'b1, 1'b0, 1'b0);

        // two hazards and three redirects for the perf counters
        for (int h = 0; h < 2; h++) begin
            step(1'b1, LW_X5,  1'b1, 1'b0, 1'b0);
            step(1'b1, ADD_65, 1'b1, 1'b0, 1'b0);
            repeat (5) step(1'b1, NOP, 1'b1, 1'b0, 1'b0);
        end
        for (int j = 0; j < 3; j++) step(1'b1, NOP, 1'b1, 1'b0, 1'b1);
        step(1'b1, NOP, 1'b0, 1'b0, 1'b0);

        // randomized traffic; redirect stays asserted across an ext_stall
        prev_es = 1'b0;
        prev_rd = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            es = ($urandom_range(0, 6) == 0);
            rd = (prev_es && prev_rd) ? 1'b1 : ($urandom_range(0, 9) == 0);
            r  = ($urandom_range(0, 799) != 0);
            step(r, rand_inst(), ($urandom_range(0, 7) != 0), es, rd);
            prev_es = es;
            prev_rd = rd;
        end
        step(1'b1, NOP, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
